ps2_rx: RTL and testbench

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ps2_rx.sv | 116 +++++++++++
 tb/tb_ps2_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with clock glitch filter, odd-parity/stop checking and inter-edge timeout.
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t                state_q, state_d;
  logic [1:0]            c_sync_q, c_sync_d, d_sync_q, d_sync_d;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;
  logic [7:0]            sh_q, sh_d, dout_q, dout_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  par_q, par_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  done_q, done_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                  fall_tick, d_s, odd_ok;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      c_sync_q  <= '1;
      d_sync_q  <= '1;
      hist_q    <= '1;
      filt_q    <= 1'b1;
      sh_q      <= '0;
      dout_q    <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_sync_q  <= c_sync_d;
      d_sync_q  <= d_sync_d;
      hist_q    <= hist_d;
      filt_q    <= filt_d;
      sh_q      <= sh_d;
      dout_q    <= dout_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end
  always_comb begin
    c_sync_d  = {c_sync_q[0], ps2c};
    d_sync_d  = {d_sync_q[0], ps2d};
    d_s       = d_sync_q[1];
    hist_d    = {hist_q[FILTER_LEN-2:0], c_sync_q[1]};
    filt_d    = (&hist_q) ? 1'b1 : (~|hist_q) ? 1'b0 : filt_q;
    fall_tick = filt_q & ~filt_d;
    odd_ok    = ^{sh_q, par_q};
    state_d   = state_q;
    sh_d      = sh_q;
    dout_d    = dout_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tmo_d     = (state_q == IDLE) ? tmo_q : fall_tick ? '0 : tmo_q + 1'b1;
    done_d    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE:
        if (fall_tick && rx_en && !d_s) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tmo_d     = '0;
        end
      DATA:
        if (fall_tick) begin
          sh_d      = {d_s, sh_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == 4'd7) ? PARITY : DATA;
        end
      PARITY:
        if (fall_tick) begin
          par_d   = d_s;
          state_d = STOP;
        end
      STOP:
        if (fall_tick) begin
          state_d = IDLE;
          done_d  = d_s & odd_ok;
          dout_d  = (d_s & odd_ok) ? sh_q : dout_q;
          perr_d  = ~odd_ok;
          ferr_d  = ~d_s;
        end
      default: state_d = IDLE;
    endcase
    // A stalled frame is abandoned once the inter-edge gap reaches the limit.
    if (state_q != IDLE && !fall_tick && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      tmo_d   = '0;
      ferr_d  = 1'b1;
    end
  end
  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed scenario bench for ps2_rx with 400-cycle PS/2 bit period.
module tb_ps2_rx;
  logic       clk = 1'b0, reset = 1'b0, ps2d = 1'b1, ps2c = 1'b1, rx_en = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick, parity_err, frame_err;
  int total = 0, bad = 0;
  int done_cnt = 0, perr_cnt = 0, ferr_cnt = 0, fall_cnt = 0, wide_cnt = 0;
  logic done_p = 1'b0, perr_p = 1'b0, ferr_p = 1'b0;
  int b_done, b_perr, b_ferr, b_fall;

  ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(2000)) dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en),
    .dout(dout), .rx_done_tick(rx_done_tick), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    done_cnt <= done_cnt + int'(rx_done_tick);
    perr_cnt <= perr_cnt + int'(parity_err);
    ferr_cnt <= ferr_cnt + int'(frame_err);
    fall_cnt <= fall_cnt + int'(dut.fall_tick);
    wide_cnt <= wide_cnt + int'((rx_done_tick & done_p) | (parity_err & perr_p) | (frame_err & ferr_p));
    done_p <= rx_done_tick;
    perr_p <= parity_err;
    ferr_p <= frame_err;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    wait_cyc(1);
    b_done = done_cnt; b_perr = perr_cnt; b_ferr = ferr_cnt; b_fall = fall_cnt;
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    wait_cyc(100);
    ps2c = 1'b0;
    wait_cyc(200);
    ps2c = 1'b1;
    wait_cyc(100);
  endtask

  task automatic send_bits(input logic [10:0] w, input int n, input bit drop_en);
    for (int i = 0; i < n; i++) begin
      send_bit(w[i]);
      if (i == 0 && drop_en) rx_en = 1'b0;
    end
    ps2d = 1'b1;
    wait_cyc(20);
  endtask

  task automatic check_counts(input string name, input int d, input int p, input int f);
    total++; if (done_cnt - b_done !== d) begin bad++; $display("FAIL %s done pulses got=%0d exp=%0d", name, done_cnt - b_done, d); end
    total++; if (perr_cnt - b_perr !== p) begin bad++; $display("FAIL %s parity_err pulses got=%0d exp=%0d", name, perr_cnt - b_perr, p); end
    total++; if (ferr_cnt - b_ferr !== f) begin bad++; $display("FAIL %s frame_err pulses got=%0d exp=%0d", name, ferr_cnt - b_ferr, f); end
  endtask

  task automatic check_dout(input string name, input logic [7:0] exp);
    total++;
    if (dout !== exp) begin bad++; $display("FAIL %s dout got=%h exp=%h", name, dout, exp); end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #3;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(5);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_async dout got=%h exp=00", dout); end
    wait_cyc(3);
    total++; if ({rx_done_tick, parity_err, frame_err} !== 3'b000) begin bad++; $display("FAIL reset pulses got=%b exp=000", {rx_done_tick, parity_err, frame_err}); end
    reset = 1'b0;
    wait_cyc(5);
    check_dout("reset", 8'h00);
  endtask

  task automatic test_parity();
    snap();
    send_bits({1'b1, 1'b1, 8'h1C, 1'b0}, 11, 0);
    check_counts("parity", 0, 1, 0);
    check_dout("parity", 8'h00);
  endtask

  task automatic test_stop_err();
    snap();
    send_bits({1'b0, 1'b0, 8'h1C, 1'b0}, 11, 0);
    check_counts("stop_err", 0, 0, 1);
    snap();
    send_bits({1'b0, 1'b1, 8'h1C, 1'b0}, 11, 0);
    check_counts("both_err", 0, 1, 1);
    check_dout("both_err", 8'h00);
  endtask

  task automatic test_glitch();
    snap();
    ps2c = 1'b0;
    wait_cyc(3);
    ps2c = 1'b1;
    wait_cyc(50);
    total++; if (fall_cnt - b_fall !== 0) begin bad++; $display("FAIL glitch fall_ticks got=%0d exp=0", fall_cnt - b_fall); end
    check_counts("glitch", 0, 0, 0);
  endtask

  task automatic test_good();
    snap();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 11, 0);
    check_counts("good", 1, 0, 0);
    check_dout("good", 8'h1C);
  endtask

  task automatic test_timeout();
    int n;
    snap();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5, 0);
    n = 0;
    while (ferr_cnt == b_ferr && n < 3000) begin wait_cyc(1); n++; end
    wait_cyc(5);
    check_counts("timeout", 0, 0, 1);
    check_dout("timeout", 8'h1C);
    snap();
    send_bits({1'b1, 1'b1, 8'hF0, 1'b0}, 11, 0);
    check_counts("after_timeout", 1, 0, 0);
    check_dout("after_timeout", 8'hF0);
  endtask

  task automatic test_reset_mid();
    snap();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6, 0);
    pulse_reset();
    check_counts("reset_mid", 0, 0, 0);
    check_dout("reset_mid", 8'h00);
    snap();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 11, 0);
    check_counts("post_reset", 1, 0, 0);
    check_dout("post_reset", 8'h1C);
  endtask

  task automatic test_rx_en();
    rx_en = 1'b0;
    snap();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 1, 0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1);
    wait_cyc(20);
    check_counts("rx_en_off", 0, 0, 0);
    rx_en = 1'b1;
    pulse_reset();
    snap();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 11, 1);
    check_counts("rx_en_drop", 1, 0, 0);
    check_dout("rx_en_drop", 8'h1C);
    rx_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_parity();
    test_stop_err();
    test_glitch();
    test_good();
    test_timeout();
    test_reset_mid();
    test_rx_en();
    wait_cyc(2);
    total++;
    if (wide_cnt !== 0) begin bad++; $display("FAIL pulse_width wide cycles got=%0d exp=0", wide_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
